// File: rtl/node_weight_pkg.sv
// rtl/node_weight_pkg.sv - shared types and weight rule for node_weight_gen
package node_weight_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DIV,
        S_WRITE,
        S_PROC,
        S_DONE
    } state_t;

    function automatic int deg_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Reciprocal of an out-degree in Q0.width: 0 for dangling, saturated for d=1.
    function automatic longint unsigned recip(input int d, input int width);
        longint unsigned one;
        one = longint'(1) << width;
        if (d == 0)
            return 0;
        else if (d == 1)
            return one - 1;
        else
            return one / longint'(d);
    endfunction

endpackage

// File: rtl/recip_div.sv
// rtl/recip_div.sv - serial restoring divider computing 2^WIDTH / divisor, one quotient bit per cycle
module recip_div #(
    parameter int WIDTH = 16,
    parameter int DEG_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [DEG_W-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic             qvalid
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [DEG_W-1:0] dsr;
    logic [DEG_W-1:0] rem;
    logic [WIDTH:0]   q;
    logic [CW-1:0]    cnt;
    logic             active;
    logic [DEG_W:0]   trial;
    logic [DEG_W:0]   diff;
    logic             take;

    // The dividend 2^WIDTH has a single set bit, consumed on the first step.
    always_comb begin
        trial = {rem, cnt == CW'(WIDTH)};
        diff  = trial - {1'b0, dsr};
        take  = trial >= {1'b0, dsr};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dsr    <= '0;
            rem    <= '0;
            q      <= '0;
            cnt    <= '0;
            active <= 1'b0;
            qvalid <= 1'b0;
        end else if (go) begin
            dsr    <= divisor;
            rem    <= '0;
            q      <= '0;
            cnt    <= CW'(WIDTH);
            active <= 1'b1;
            qvalid <= 1'b0;
        end else if (active) begin
            rem <= take ? diff[DEG_W-1:0] : trial[DEG_W-1:0];
            q   <= {q[WIDTH-1:0], take};
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                active <= 1'b0;
                qvalid <= 1'b1;
            end
        end
    end

    assign quot = (dsr == '0) ? '0 : (q[WIDTH] ? '1 : q[WIDTH-1:0]);

endmodule

// File: rtl/node_weight_gen.sv
// rtl/node_weight_gen.sv - per-node out-degree reciprocal weights; NODE_WEIGHT_LUT_EN selects ROM instead of divider
module node_weight_gen
    import node_weight_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N*N-1:0]     adj,
    output logic               busy,
    output logic               done,
    output logic [N*WIDTH-1:0] nodeWeight,
    output logic [N-1:0]       dangling
);
    localparam int DEG_W = deg_w(N);
    localparam int IW    = $clog2(N);

    state_t           state;
    logic [N*N-1:0]   adj_q;
    logic [IW-1:0]    idx;
    logic [DEG_W-1:0] col_deg;

    // Out-degree of the current node is the popcount of its adjacency column.
    always_comb begin
        col_deg = '0;
        for (int i = 0; i < N; i++)
            col_deg = col_deg + DEG_W'(adj_q[i*N + int'(idx)]);
    end

`ifdef NODE_WEIGHT_LUT_EN
    logic [WIDTH-1:0] rom [N+1];

    for (genvar k = 0; k <= N; k++) begin : g_rom
        assign rom[k] = WIDTH'(recip(k, WIDTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            adj_q      <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            nodeWeight <= '0;
            dangling   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    adj_q <= adj;
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= S_PROC;
                end
                S_PROC: begin
                    nodeWeight[int'(idx)*WIDTH +: WIDTH] <= rom[col_deg];
                    dangling[idx] <= (col_deg == '0);
                    if (int'(idx) == N - 1) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    localparam int CW = $clog2(WIDTH + 1);

    logic [DEG_W-1:0] deg_q;
    logic [CW-1:0]    div_cnt;
    logic [WIDTH-1:0] quot;
    logic             qvalid;

    recip_div #(.WIDTH(WIDTH), .DEG_W(DEG_W)) u_div (
        .clk     (clk),
        .reset   (reset),
        .go      (state == S_COUNT),
        .divisor (col_deg),
        .quot    (quot),
        .qvalid  (qvalid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            adj_q      <= '0;
            idx        <= '0;
            deg_q      <= '0;
            div_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            nodeWeight <= '0;
            dangling   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    adj_q <= adj;
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= S_COUNT;
                end
                S_COUNT: begin
                    deg_q   <= col_deg;
                    div_cnt <= '0;
                    state   <= S_DIV;
                end
                // Fixed WIDTH+1 cycles regardless of degree so job timing never varies.
                S_DIV: begin
                    if (div_cnt == CW'(WIDTH))
                        state <= S_WRITE;
                    else
                        div_cnt <= div_cnt + 1'b1;
                end
                S_WRITE: begin
                    nodeWeight[int'(idx)*WIDTH +: WIDTH] <= qvalid ? quot : '0;
                    dangling[idx] <= (deg_q == '0);
                    if (int'(idx) == N - 1) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_COUNT;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_node_weight_gen.sv
// tb/tb_node_weight_gen.sv - randomized self-checking bench for node_weight_gen against a degree/reciprocal model
module tb_node_weight_gen;
    localparam int N = 4;
    localparam int W = 16;
`ifdef NODE_WEIGHT_LUT_EN
    localparam int LAT = N;
`else
    localparam int LAT = N * (W + 3);
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [N*N-1:0]   adj;
    logic             busy;
    logic             done;
    logic [N*W-1:0]   nodeWeight;
    logic [N-1:0]     dangling;

    int vectors = 0;
    int errors  = 0;

    node_weight_gen #(.N(N), .WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .adj        (adj),
        .busy       (busy),
        .done       (done),
        .nodeWeight (nodeWeight),
        .dangling   (dangling)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [N*N-1:0] a, output logic [N*W-1:0] w,
                                  output logic [N-1:0] dg);
        longint d;
        longint full;
        full = longint'(1) << W;
        w  = '0;
        dg = '0;
        for (int j = 0; j < N; j++) begin
            d = 0;
            for (int i = 0; i < N; i++)
                d += longint'(a[i*N + j]);
            if (d == 0)
                dg[j] = 1'b1;
            else if (d == 1)
                w[j*W +: W] = W'(full - 1);
            else
                w[j*W +: W] = W'(full / d);
        end
    endfunction

    task automatic run_job(input logic [N*N-1:0] a, input string name);
        logic [N*W-1:0] ew;
        logic [N-1:0]   ed;
        int             lat;
        model(a, ew, ed);
        adj   = a;
        start = 1'b1;
        tick();
        start = 1'b0;
        adj   = N*N'($urandom);
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_accept: got %b expected 1", name, busy);
        end
        lat = -1;
        for (int k = 1; k <= LAT + 10; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        vectors++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL %s done_latency: got %0d expected %0d", name, lat, LAT);
        end
        vectors++;
        if (nodeWeight !== ew) begin
            errors++;
            $display("FAIL %s nodeWeight: got %h expected %h", name, nodeWeight, ew);
        end
        vectors++;
        if (dangling !== ed) begin
            errors++;
            $display("FAIL %s dangling: got %b expected %b", name, dangling, ed);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        adj   = '0;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if ({busy, done, nodeWeight, dangling} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b w=%h dg=%b expected all 0",
                     busy, done, nodeWeight, dangling);
        end
    endtask

    task automatic test_reference();
        run_job(16'h3B1C, "reference");
        vectors++;
        if (nodeWeight !== 64'h8000_FFFF_8000_5555) begin
            errors++;
            $display("FAIL reference_const: got %h expected 8000ffff80005555", nodeWeight);
        end
    endtask

    task automatic test_all_ones();
        run_job('1, "all_ones");
        vectors++;
        if (nodeWeight !== {N{16'h4000}}) begin
            errors++;
            $display("FAIL all_ones_const: got %h expected 4000 in every slot", nodeWeight);
        end
    endtask

    task automatic test_dangling();
        logic [N*N-1:0] a;
        a = N*N'($urandom);
        for (int i = 0; i < N; i++) begin
            a[i*N + 1] = 1'b0;
            if (i != 1) a[i*N + i] = 1'b1;
        end
        run_job(a, "dangling");
        vectors++;
        if (dangling !== 4'b0010 || nodeWeight[W +: W] !== '0) begin
            errors++;
            $display("FAIL dangling_const: got dg=%b slot1=%h expected 0010 0000",
                     dangling, nodeWeight[W +: W]);
        end
    endtask

    task automatic test_start_held();
        logic [N*N-1:0] b;
        logic [N*W-1:0] ew;
        logic [N-1:0]   ed;
        int             dones;
        int             lat;
        b = N*N'($urandom);
        model(b, ew, ed);
        adj   = 16'hFFFF;
        start = 1'b1;
        tick();
        dones = 0;
        lat   = -1;
        for (int k = 1; k <= LAT + 10; k++) begin
            tick();
            if (done === 1'b1) begin
                dones++;
                if (lat < 0) lat = k;
            end
            if (lat >= 0) break;
        end
        vectors++;
        if (lat != LAT || dones != 1) begin
            errors++;
            $display("FAIL held_first_job: got lat=%0d dones=%0d expected %0d 1", lat, dones, LAT);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL held_idle_gap: got busy=%b done=%b expected 0 0", busy, done);
        end
        adj = b;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL held_reaccept: got busy=%b expected 1", busy);
        end
        lat = -1;
        for (int k = 1; k <= LAT + 10; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        vectors++;
        if (lat != LAT || nodeWeight !== ew || dangling !== ed) begin
            errors++;
            $display("FAIL held_second_job: got lat=%0d w=%h dg=%b expected %0d %h %b",
                     lat, nodeWeight, dangling, LAT, ew, ed);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int dones;
        adj   = 16'h3B1C;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 30; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({busy, done, nodeWeight, dangling} !== '0) begin
            errors++;
            $display("FAIL mid_reset_clear: got busy=%b done=%b w=%h dg=%b expected all 0",
                     busy, done, nodeWeight, dangling);
        end
        dones = 0;
        for (int k = 0; k < LAT + 10; k++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        vectors++;
        if (dones != 0 || nodeWeight !== '0) begin
            errors++;
            $display("FAIL mid_reset_discard: got dones=%0d w=%h expected 0 0", dones, nodeWeight);
        end
        run_job(16'hA5C3, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [N*N-1:0] a;
        for (int r = 0; r < 12; r++) begin
            a = N*N'($urandom);
            if (r % 3 == 0) begin
                for (int i = 0; i < N; i++) a[i*N + (r % N)] = 1'b0;
            end
            run_job(a, "random");
        end
    endtask

    initial begin
        test_reset();
        test_reference();
        test_all_ones();
        test_dangling();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
